// File: rtl/dual_port_ram_sync_init.sv
// -----------------------------------------------------------------------------
// dual_port_ram_sync_init
//
// Single-clock true dual-port RAM with a clear sequencer that runs after reset.
// Two access ports (A and B) share one storage array. After every reset a
// sweep writes INIT_VALUE to every location, one word per cycle. Port requests
// are ignored until the sweep completes.
//
// Access rules once the sweep is done:
//   - Reads are registered, so data appears one cycle after the address.
//   - A read and a write to the same address in the same cycle return the old
//     contents (read-first).
//   - If both ports write the same address, port A wins and collision pulses
//     high for one cycle.
//   - Addresses at or above DEPTH are treated as holes: writes are dropped,
//     reads return 0, and no collision is flagged.
//
// Optional build macro:
//   DPRAM_PARITY_EN - store one even-parity bit per word and check it on every
//                     enabled read. When this macro is undefined, both
//                     parity_error outputs are tied to 0.
//
// Parameters:
//   DATA_WIDTH  word width in bits
//   ADDR_WIDTH  address width in bits
//   DEPTH       number of words (must be <= 2**ADDR_WIDTH)
//   INIT_VALUE  word written to every location during the clear sweep
//
// Ports:
//   clk              clock for all logic (rising edge)
//   reset            synchronous, active-high reset
//   write_enable_a/b port write request
//   output_enable_a/b port read enable
//   address_a/b      port address
//   data_in_a/b      port write data
//   data_out_a/b     registered read data (0 when not enabled)
//   init_busy        high while the clear sweep runs
//   collision        one-cycle pulse when both ports write the same address
//   parity_error_a/b registered parity mismatch on a read (parity build only)
// -----------------------------------------------------------------------------
module dual_port_ram_sync_init #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DEPTH      = 2 ** ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_enable_a,
    input  logic                  output_enable_a,
    input  logic [ADDR_WIDTH-1:0] address_a,
    input  logic [DATA_WIDTH-1:0] data_in_a,
    output logic [DATA_WIDTH-1:0] data_out_a,
    input  logic                  write_enable_b,
    input  logic                  output_enable_b,
    input  logic [ADDR_WIDTH-1:0] address_b,
    input  logic [DATA_WIDTH-1:0] data_in_b,
    output logic [DATA_WIDTH-1:0] data_out_b,
    output logic                  init_busy,
    output logic                  collision,
    output logic                  parity_error_a,
    output logic                  parity_error_b
);

    // Depth widened by one bit so the range check also works when DEPTH equals
    // 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   counter_q, counter_d;
    logic                    collision_q, collision_d;
    logic                    ready;

    // Port signals packed so both ports can share one generate loop.
    // Index 0 is port A; index 1 is port B.
    logic [1:0]                  we_p;
    logic [1:0]                  oe_p;
    logic [1:0][ADDR_WIDTH-1:0]  addr_p;
    logic [1:0][DATA_WIDTH-1:0]  din_p;
    logic [1:0]                  in_range;

    assign we_p   = {write_enable_b, write_enable_a};
    assign oe_p   = {output_enable_b, output_enable_a};
    assign addr_p = {address_b, address_a};
    assign din_p  = {data_in_b, data_in_a};

    assign ready  = (state_q == ST_READY);

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

`ifdef DPRAM_PARITY_EN
    // Parity is kept as a flat vector. This makes every stored parity bit
    // individually addressable, separate from the data array.
    logic [DEPTH-1:0] parity_mem;
`endif

    // -------------------------------------------------------------------------
    // Clear sequencer
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        case (state_q)
            ST_CLEAR: begin
                counter_d = counter_q + ADDR_WIDTH'(1);
                // Leave on the same edge that writes the final location.
                if (counter_q == LAST_ADDR) begin
                    state_d   = ST_READY;
                    counter_d = '0;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d   = ST_CLEAR;
                counter_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
        end
    end

    assign init_busy = (state_q == ST_CLEAR);

    // -------------------------------------------------------------------------
    // Range check per port
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_range
            assign in_range[gi] = ({1'b0, addr_p[gi]} < DEPTH_EXT);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Write path
    // -------------------------------------------------------------------------
    // The sweep borrows write port 0. Port B's write is suppressed when port A
    // writes the same valid address, so port A wins the collision.
    logic                  wr_en_a, wr_en_b;
    logic [ADDR_WIDTH-1:0] wr_addr_a, wr_addr_b;
    logic [DATA_WIDTH-1:0] wr_data_a, wr_data_b;
    logic                  same_addr;

    assign same_addr = (address_a == address_b);

    always_comb begin
        wr_en_a     = 1'b0;
        wr_addr_a   = address_a;
        wr_data_a   = data_in_a;
        wr_en_b     = 1'b0;
        wr_addr_b   = address_b;
        wr_data_b   = data_in_b;
        collision_d = 1'b0;
        if (state_q == ST_CLEAR) begin
            wr_en_a   = 1'b1;
            wr_addr_a = counter_q;
            wr_data_a = INIT_VALUE;
        end else begin
            wr_en_a     = we_p[0] & in_range[0];
            wr_en_b     = we_p[1] & in_range[1] & ~(wr_en_a & same_addr);
            // Both ports are in range when the addresses match and A is in
            // range, so out-of-range hole writes never flag a collision.
            collision_d = we_p[0] & we_p[1] & in_range[0] & same_addr;
        end
    end

    // Both write ports update storage in one process. The write enables are
    // mutually exclusive on a shared address. A reset edge writes nothing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wr_en_a) begin
                mem[wr_addr_a] <= wr_data_a;
`ifdef DPRAM_PARITY_EN
                parity_mem[wr_addr_a] <= ^wr_data_a;
`endif
            end
            if (wr_en_b) begin
                mem[wr_addr_b] <= wr_data_b;
`ifdef DPRAM_PARITY_EN
                parity_mem[wr_addr_b] <= ^wr_data_b;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= collision_d;
        end
    end

    assign collision = collision_q;

    // -------------------------------------------------------------------------
    // Read path, one registered read port per access port
    // -------------------------------------------------------------------------
    // The read data comes from the array before this edge's writes land. This
    // gives read-first behaviour on same-address read/write.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
            logic                  parity_error_q, parity_error_d;

            always_comb begin
                data_out_d     = '0;
                parity_error_d = 1'b0;
                if (ready && oe_p[gi] && in_range[gi]) begin
                    data_out_d = mem[addr_p[gi]];
`ifdef DPRAM_PARITY_EN
                    parity_error_d = (^mem[addr_p[gi]]) ^ parity_mem[addr_p[gi]];
`endif
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    data_out_q     <= '0;
                    parity_error_q <= 1'b0;
                end else begin
                    data_out_q     <= data_out_d;
                    parity_error_q <= parity_error_d;
                end
            end
        end
    endgenerate

    assign data_out_a     = g_port[0].data_out_q;
    assign data_out_b     = g_port[1].data_out_q;
    assign parity_error_a = g_port[0].parity_error_q;
    assign parity_error_b = g_port[1].parity_error_q;

endmodule

// File: tb/tb_dual_port_ram_sync_init.sv
// -----------------------------------------------------------------------------
// tb_dual_port_ram_sync_init
//
// Directed bench for dual_port_ram_sync_init. Three instances share one set of
// port inputs:
//   dut0  default parameters (INIT_VALUE 0, DEPTH 256)
//   dut_i INIT_VALUE 8'hA5
//   dut_s DEPTH 200, which leaves address holes at 200..255
// A vector table covers the single-cycle access rules. Hand-written sequences
// cover the clear sweep, the address holes, reset mid-sweep, and parity
// (the parity check needs DPRAM_PARITY_EN).
// -----------------------------------------------------------------------------
module tb_dual_port_ram_sync_init;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       we_a, oe_a, we_b, oe_b;
    logic [7:0] addr_a, din_a, addr_b, din_b;

    logic [7:0] d0_out_a, d0_out_b, di_out_a, di_out_b, ds_out_a, ds_out_b;
    logic       d0_busy, d0_coll, d0_pea, d0_peb;
    logic       di_busy, di_coll, di_pea, di_peb;
    logic       ds_busy, ds_coll, ds_pea, ds_peb;

    dual_port_ram_sync_init dut0 (
        .clk(clk), .reset(reset),
        .write_enable_a(we_a), .output_enable_a(oe_a), .address_a(addr_a),
        .data_in_a(din_a), .data_out_a(d0_out_a),
        .write_enable_b(we_b), .output_enable_b(oe_b), .address_b(addr_b),
        .data_in_b(din_b), .data_out_b(d0_out_b),
        .init_busy(d0_busy), .collision(d0_coll),
        .parity_error_a(d0_pea), .parity_error_b(d0_peb)
    );

    dual_port_ram_sync_init #(.INIT_VALUE(8'hA5)) dut_i (
        .clk(clk), .reset(reset),
        .write_enable_a(we_a), .output_enable_a(oe_a), .address_a(addr_a),
        .data_in_a(din_a), .data_out_a(di_out_a),
        .write_enable_b(we_b), .output_enable_b(oe_b), .address_b(addr_b),
        .data_in_b(din_b), .data_out_b(di_out_b),
        .init_busy(di_busy), .collision(di_coll),
        .parity_error_a(di_pea), .parity_error_b(di_peb)
    );

    dual_port_ram_sync_init #(.DEPTH(200)) dut_s (
        .clk(clk), .reset(reset),
        .write_enable_a(we_a), .output_enable_a(oe_a), .address_a(addr_a),
        .data_in_a(din_a), .data_out_a(ds_out_a),
        .write_enable_b(we_b), .output_enable_b(oe_b), .address_b(addr_b),
        .data_in_b(din_b), .data_out_b(ds_out_b),
        .init_busy(ds_busy), .collision(ds_coll),
        .parity_error_a(ds_pea), .parity_error_b(ds_peb)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic       we_a;
        logic       oe_a;
        logic [7:0] addr_a;
        logic [7:0] din_a;
        logic       we_b;
        logic       oe_b;
        logic [7:0] addr_b;
        logic [7:0] din_b;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic       exp_coll;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic wa, input logic oa, input logic [7:0] aa,
                                input logic [7:0] da, input logic wb, input logic ob,
                                input logic [7:0] ab, input logic [7:0] db,
                                input logic [7:0] ea, input logic [7:0] eb,
                                input logic ec);
        vec_t v;
        v.we_a = wa; v.oe_a = oa; v.addr_a = aa; v.din_a = da;
        v.we_b = wb; v.oe_b = ob; v.addr_b = ab; v.din_b = db;
        v.exp_a = ea; v.exp_b = eb; v.exp_coll = ec;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_a = 1'b0; oe_a = 1'b0; addr_a = 8'h00; din_a = 8'h00;
        we_b = 1'b0; oe_b = 1'b0; addr_b = 8'h00; din_b = 8'h00;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        int c0, ci, cs, bad;

        // Table: A/B access patterns, registered outputs expected after one edge.
        //            weA  oeA  addrA  dinA   weB  oeB  addrB  dinB   expA   expB  coll
        vecs[0]  = mk(1'b1,1'b0,8'h10,8'h3C, 1'b0,1'b1,8'h10,8'h00, 8'h00,8'h00,1'b0); // B reads old
        vecs[1]  = mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b1,8'h10,8'h00, 8'h00,8'h3C,1'b0); // new visible
        vecs[2]  = mk(1'b1,1'b0,8'h20,8'h11, 1'b1,1'b0,8'h20,8'h22, 8'h00,8'h00,1'b1); // collision
        vecs[3]  = mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 8'h00,8'h00,1'b0); // pulse ends
        vecs[4]  = mk(1'b0,1'b1,8'h20,8'h00, 1'b0,1'b1,8'h20,8'h00, 8'h11,8'h11,1'b0); // A won
        vecs[5]  = mk(1'b1,1'b0,8'h30,8'h5A, 1'b1,1'b0,8'h31,8'hA5, 8'h00,8'h00,1'b0); // two writes
        vecs[6]  = mk(1'b0,1'b1,8'h31,8'h00, 1'b0,1'b1,8'h30,8'h00, 8'hA5,8'h5A,1'b0);
        vecs[7]  = mk(1'b1,1'b1,8'h40,8'h99, 1'b0,1'b0,8'h00,8'h00, 8'h00,8'h00,1'b0); // A read-first
        vecs[8]  = mk(1'b0,1'b1,8'h40,8'h00, 1'b0,1'b1,8'h10,8'h00, 8'h99,8'h3C,1'b0);
        vecs[9]  = mk(1'b0,1'b0,8'h40,8'h00, 1'b0,1'b1,8'h40,8'h00, 8'h00,8'h99,1'b0); // oe low -> 0
        vecs[10] = mk(1'b1,1'b0,8'hFF,8'h01, 1'b1,1'b0,8'h00,8'h02, 8'h00,8'h00,1'b0); // edge addrs
        vecs[11] = mk(1'b0,1'b1,8'h00,8'h00, 1'b0,1'b1,8'hFF,8'h00, 8'h02,8'h01,1'b0);
        vecs[12] = mk(1'b1,1'b1,8'h20,8'h33, 1'b1,1'b1,8'h20,8'h44, 8'h11,8'h11,1'b1); // coll + read
        vecs[13] = mk(1'b0,1'b1,8'h20,8'h00, 1'b0,1'b1,8'h20,8'h00, 8'h33,8'h33,1'b0);

        // ---------------- reset state, reset held for two edges -------------
        idle();
        reset = 1'b1;
        tick();
        tick();
        chk("reset_busy",  {31'd0, d0_busy}, 32'd1);
        chk("reset_out_a", {24'd0, d0_out_a}, 32'h0);
        chk("reset_out_b", {24'd0, d0_out_b}, 32'h0);
        chk("reset_coll",  {31'd0, d0_coll}, 32'd0);
        chk("reset_pe_a",  {31'd0, d0_pea}, 32'd0);
        chk("reset_pe_b",  {31'd0, d0_peb}, 32'd0);
        reset = 1'b0;

        // ---------------- sweep length -------------------------------------
        c0 = 0; ci = 0; cs = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!(d0_busy || di_busy || ds_busy)) break;
            c0 += int'(d0_busy);
            ci += int'(di_busy);
            cs += int'(ds_busy);
            tick();
        end
        chk("sweep_len_d0", c0, 256);
        chk("sweep_len_init", ci, 256);
        chk("sweep_len_d200", cs, 200);
        $display("sweep: busy cycles d0=%0d init=%0d depth200=%0d", c0, ci, cs);

        // ---------------- every location holds INIT_VALUE ------------------
        chk("pre_read_out_a", {24'd0, di_out_a}, 32'h0);
        for (int i = 0; i < 256; i++) begin
            oe_a = 1'b1; addr_a = 8'(i);
            oe_b = 1'b1; addr_b = 8'(255 - i);
            tick();
            chk($sformatf("init0_a[%0d]", i), {24'd0, d0_out_a}, 32'h00);
            chk($sformatf("init0_b[%0d]", 255 - i), {24'd0, d0_out_b}, 32'h00);
            chk($sformatf("initA5_a[%0d]", i), {24'd0, di_out_a}, 32'hA5);
            chk($sformatf("initA5_b[%0d]", 255 - i), {24'd0, di_out_b}, 32'hA5);
        end
        idle();
        tick();
        chk("oe_off_a", {24'd0, di_out_a}, 32'h0);
        chk("oe_off_b", {24'd0, di_out_b}, 32'h0);

        // ---------------- table-driven single-cycle vectors ----------------
        for (int k = 0; k < NVEC; k++) begin
            we_a = vecs[k].we_a; oe_a = vecs[k].oe_a; addr_a = vecs[k].addr_a; din_a = vecs[k].din_a;
            we_b = vecs[k].we_b; oe_b = vecs[k].oe_b; addr_b = vecs[k].addr_b; din_b = vecs[k].din_b;
            tick();
            chk($sformatf("vec%0d_out_a", k), {24'd0, d0_out_a}, {24'd0, vecs[k].exp_a});
            chk($sformatf("vec%0d_out_b", k), {24'd0, d0_out_b}, {24'd0, vecs[k].exp_b});
            chk($sformatf("vec%0d_coll", k), {31'd0, d0_coll}, {31'd0, vecs[k].exp_coll});
            $display("vec %0d: A we=%0b oe=%0b @%02h din=%02h -> %02h | B we=%0b oe=%0b @%02h din=%02h -> %02h | coll=%0b",
                     k, we_a, oe_a, addr_a, din_a, d0_out_a, we_b, oe_b, addr_b, din_b, d0_out_b, d0_coll);
        end
        idle();

        // ---------------- address holes (DEPTH 200 instance) ---------------
        we_a = 1'b1; addr_a = 8'd210; din_a = 8'h11;
        we_b = 1'b1; addr_b = 8'd210; din_b = 8'h22;
        tick();
        chk("hole_coll_d0", {31'd0, d0_coll}, 32'd1);
        chk("hole_coll_d200", {31'd0, ds_coll}, 32'd0);
        idle();
        oe_a = 1'b1; addr_a = 8'd210;
        oe_b = 1'b1; addr_b = 8'd210;
        tick();
        chk("hole_rd_d0_a", {24'd0, d0_out_a}, 32'h11);
        chk("hole_rd_d0_b", {24'd0, d0_out_b}, 32'h11);
        chk("hole_rd_d200_a", {24'd0, ds_out_a}, 32'h0);
        chk("hole_rd_d200_b", {24'd0, ds_out_b}, 32'h0);
        $display("hole: @210 d0=%02h/%02h depth200=%02h/%02h", d0_out_a, d0_out_b, ds_out_a, ds_out_b);
        idle();
        we_a = 1'b1; addr_a = 8'd199; din_a = 8'h6B;
        tick();
        idle();
        oe_a = 1'b1; addr_a = 8'd199;
        tick();
        chk("last_addr_d200", {24'd0, ds_out_a}, 32'h6B);
        $display("last: @199 depth200=%02h", ds_out_a);
        idle();

        // ---------------- reset mid-sweep ----------------------------------
        we_a = 1'b1; addr_a = 8'h05; din_a = 8'h77;
        tick();
        idle();
        oe_b = 1'b1; addr_b = 8'h05;
        tick();
        chk("pre_reset_rd5", {24'd0, d0_out_b}, 32'h77);
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        chk("mid_sweep_busy", {31'd0, d0_busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        c0 = 0; bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!d0_busy) break;
            c0++;
            if (d0_out_a != 8'h00 || d0_out_b != 8'h00 || d0_coll) bad++;
            we_a = 1'b1; oe_a = 1'b1; addr_a = 8'h05; din_a = 8'hEE;
            we_b = 1'b1; oe_b = 1'b1; addr_b = 8'h10; din_b = 8'hEE;
            tick();
        end
        idle();
        chk("resweep_len", c0, 256);
        chk("sweep_outputs_quiet", bad, 0);
        $display("resweep: busy cycles=%0d", c0);
        oe_a = 1'b1; addr_a = 8'h05;
        oe_b = 1'b1; addr_b = 8'h10;
        tick();
        chk("post_sweep_rd5", {24'd0, d0_out_a}, 32'h0);
        chk("post_sweep_rd10", {24'd0, d0_out_b}, 32'h0);
        addr_a = 8'h20; addr_b = 8'hFF;
        tick();
        chk("post_sweep_rd20", {24'd0, d0_out_a}, 32'h0);
        chk("post_sweep_rdff", {24'd0, d0_out_b}, 32'h0);
        $display("post-sweep: @05/@10 cleared, @20=%02h @FF=%02h", d0_out_a, d0_out_b);
        idle();

        // ---------------- parity --------------------------------------------
        we_a = 1'b1; addr_a = 8'h03; din_a = 8'h0F;
        tick();
        idle();
        oe_b = 1'b1; addr_b = 8'h03;
        tick();
        chk("par_clean_data", {24'd0, d0_out_b}, 32'h0F);
        chk("par_clean_err", {31'd0, d0_peb}, 32'd0);
`ifdef DPRAM_PARITY_EN
        force dut0.parity_mem[3] = 1'b1;
        tick();
        chk("par_forced_data", {24'd0, d0_out_b}, 32'h0F);
        chk("par_forced_err", {31'd0, d0_peb}, 32'd1);
        $display("parity: forced read @03 data=%02h err=%0b", d0_out_b, d0_peb);
        release dut0.parity_mem[3];
        addr_b = 8'h04;
        tick();
        chk("par_next_err", {31'd0, d0_peb}, 32'd0);
`endif
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
